// File: rtl/updown_pkg.sv
// Shared direction/mode encodings for the up/down modulo counter family.
package updown_pkg;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/updown_next.sv
// Combinational next-state for the counter: one compare/step level, no registers.
module updown_next
    import updown_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] limit,
    input  logic             control,
    input  logic             mode,
    output logic [WIDTH-1:0] next_count,
    output logic             next_tc
);
    always_comb begin
        next_count = count;
        next_tc    = 1'b0;
        if (control == DIR_UP) begin
            // >= rather than == so a count left above a lowered limit still terminates
            if (count >= limit) begin
                next_tc    = 1'b1;
                next_count = (mode == MODE_SAT) ? limit : '0;
            end else begin
                next_count = count + WIDTH'(1);
            end
        end else begin
            if (count > limit) begin
                next_count = limit;
            end else if (count == '0) begin
                next_tc    = 1'b1;
                next_count = (mode == MODE_WRAP) ? limit : '0;
            end else begin
                next_count = count - WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/updown_mod_counter.sv
// Loadable up/down counter over [0, limit] with wrap/saturate ends and a registered tc pulse.
module updown_mod_counter
    import updown_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             control,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_tc;
    logic [WIDTH-1:0] w_load_val;

    updown_next #(.WIDTH(WIDTH)) u_next (
        .count      (r_count),
        .limit      (limit),
        .control    (control),
        .mode       (mode),
        .next_count (w_next_count),
        .next_tc    (w_next_tc)
    );

    // Out-of-range loads clamp to the current limit
    assign w_load_val = (data_in > limit) ? limit : data_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= WIDTH'(RESET_VAL);
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_val;
            r_tc    <= 1'b0;
        end else if (en) begin
            r_count <= w_next_count;
            r_tc    <= w_next_tc;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count  = r_count;
    assign tc     = r_tc;
    assign at_max = (r_count >= limit);
    assign at_min = (r_count == '0);
endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: directed vectors push hand-computed results, a negedge monitor pops and compares.
module tb_updown_mod_counter;
    logic       clk = 1'b0;
    logic       rst, en, load, control, mode;
    logic [3:0] data_in, limit;
    logic [3:0] count;
    logic       tc, at_max, at_min;

    typedef struct {
        logic [3:0] cnt;
        logic       tc;
        logic       mx;
        logic       mn;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_push = 0;

    updown_mod_counter #(.WIDTH(4), .RESET_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .control(control),
        .mode(mode), .data_in(data_in), .limit(limit),
        .count(count), .tc(tc), .at_max(at_max), .at_min(at_min)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then queue the result expected after that edge
    task automatic step(input logic r, input logic ld, input logic e, input logic c,
                        input logic m, input logic [3:0] d, input logic [3:0] lim,
                        input logic [3:0] xc, input logic xt, input logic xmx,
                        input logic xmn, input string nm);
        exp_t x;
        rst = r; load = ld; en = e; control = c; mode = m; data_in = d; limit = lim;
        @(posedge clk);
        #1;
        x.cnt = xc; x.tc = xt; x.mx = xmx; x.mn = xmn; x.name = nm;
        q.push_back(x);
        n_push++;
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (count !== e.cnt || tc !== e.tc || at_max !== e.mx || at_min !== e.mn) begin
                n_miss++;
                $display("FAIL %s: got count=%0d tc=%b at_max=%b at_min=%b, expected count=%0d tc=%b at_max=%b at_min=%b",
                         e.name, count, tc, at_max, at_min, e.cnt, e.tc, e.mx, e.mn);
            end
        end
    end

    initial begin
        //        rst ld en ctl md din   lim    cnt   tc mx mn
        step(1, 0, 0, 1, 0, 4'd0,  4'd15, 4'd0,  0, 0, 1, "reset");
        step(0, 1, 0, 1, 0, 4'd5,  4'd15, 4'd5,  0, 0, 0, "load5");
        // up wrap, limit 9
        step(0, 1, 0, 1, 0, 4'd7,  4'd9,  4'd7,  0, 0, 0, "load7");
        step(0, 0, 1, 1, 0, 4'd0,  4'd9,  4'd8,  0, 0, 0, "up8");
        step(0, 0, 1, 1, 0, 4'd0,  4'd9,  4'd9,  0, 1, 0, "up9");
        step(0, 0, 1, 1, 0, 4'd0,  4'd9,  4'd0,  1, 0, 1, "wrap0");
        step(0, 0, 1, 1, 0, 4'd0,  4'd9,  4'd1,  0, 0, 0, "up1");
        // down saturate, limit 12
        step(0, 1, 0, 0, 1, 4'd2,  4'd12, 4'd2,  0, 0, 0, "load2");
        step(0, 0, 1, 0, 1, 4'd0,  4'd12, 4'd1,  0, 0, 0, "dn1");
        step(0, 0, 1, 0, 1, 4'd0,  4'd12, 4'd0,  0, 0, 1, "dn0");
        step(0, 0, 1, 0, 1, 4'd0,  4'd12, 4'd0,  1, 0, 1, "sat0a");
        step(0, 0, 1, 0, 1, 4'd0,  4'd12, 4'd0,  1, 0, 1, "sat0b");
        step(0, 0, 1, 1, 1, 4'd0,  4'd12, 4'd1,  0, 0, 0, "satup1");
        // clamp and limit lowered mid-count
        step(0, 1, 0, 1, 0, 4'd14, 4'd10, 4'd10, 0, 1, 0, "clamp");
        step(0, 0, 1, 0, 0, 4'd0,  4'd6,  4'd6,  0, 1, 0, "dnlim");
        step(0, 0, 1, 0, 0, 4'd0,  4'd6,  4'd5,  0, 0, 0, "dn5");
        // priority
        step(1, 1, 1, 1, 0, 4'd9,  4'd6,  4'd0,  0, 0, 1, "rstload");
        step(0, 1, 1, 1, 0, 4'd3,  4'd6,  4'd3,  0, 0, 0, "loadwins");
        // full range
        step(0, 1, 0, 0, 0, 4'd0,  4'd15, 4'd0,  0, 0, 1, "load0");
        step(0, 0, 1, 0, 0, 4'd0,  4'd15, 4'd15, 1, 1, 0, "dnwrap");
        step(0, 0, 0, 0, 0, 4'd0,  4'd15, 4'd15, 0, 1, 0, "hold1");
        step(0, 0, 0, 1, 1, 4'd0,  4'd15, 4'd15, 0, 1, 0, "hold2");
        step(0, 0, 0, 1, 0, 4'd0,  4'd15, 4'd15, 0, 1, 0, "hold3");
        step(0, 0, 1, 1, 0, 4'd0,  4'd15, 4'd0,  1, 0, 1, "upwrapfull");
        step(0, 1, 0, 1, 1, 4'd15, 4'd15, 4'd15, 0, 1, 0, "load15");
        step(0, 0, 1, 1, 1, 4'd0,  4'd15, 4'd15, 1, 1, 0, "satup15");
        // above-limit count pulled back by saturating up
        step(0, 1, 0, 1, 1, 4'd12, 4'd15, 4'd12, 0, 0, 0, "load12");
        step(0, 0, 1, 1, 1, 4'd0,  4'd8,  4'd8,  1, 1, 0, "satpull");
        // limit zero
        step(0, 1, 0, 1, 1, 4'd0,  4'd0,  4'd0,  0, 1, 1, "lim0load");
        step(0, 0, 1, 1, 1, 4'd0,  4'd0,  4'd0,  1, 1, 1, "lim0up");
        step(0, 0, 1, 0, 0, 4'd0,  4'd0,  4'd0,  1, 1, 1, "lim0dn");
        // reset mid-count, then count from reset value
        step(0, 1, 0, 1, 0, 4'd4,  4'd15, 4'd4,  0, 0, 0, "load4");
        step(1, 0, 1, 1, 0, 4'd0,  4'd15, 4'd0,  0, 0, 1, "rstmid");
        step(0, 0, 1, 1, 0, 4'd0,  4'd15, 4'd1,  0, 0, 0, "afterrst");

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0 || n_vec != n_push) begin
            n_miss++;
            $display("FAIL drain: checked %0d of %0d queued vectors", n_vec, n_push);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised successor to the team's 4-bit loadable up/down counter. Counts up or down over a programmable range `[0, limit]`, with parallel load and a run enable. Selectable wrap or saturate behaviour at the range ends, and a registered terminal-count pulse. It serves as the general-purpose loadable counter for timers, address sequencers and rate dividers in the design.

## Interface
Parameters:
- `WIDTH`, 4: counter and data width in bits (≥ 2)
- `RESET_VAL`, 0: value `count` takes on reset (must be < 2^WIDTH)

Ports:
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: reset, synchronous and active-high
- `en` in 1: count enable; counter holds when low (load still honoured)
- `load` in 1: parallel load of `data_in`
- `control` in 1: direction; 1 = up, 0 = down
- `mode` in 1: 0 = wrap, 1 = saturate
- `data_in` in WIDTH: load value
- `limit` in WIDTH: upper bound of the count range (inclusive)
- `count` out WIDTH: registered counter value
- `tc` out 1: registered terminal-count pulse
- `at_max` out 1: combinational, `count >= limit`
- `at_min` out 1: combinational, `count == 0`

## Operation
- Priority each rising edge: `rst` > `load` > `en` > hold.
- Reset: `count` = RESET_VAL, `tc` = 0. This happens regardless of `load`, `en` or an in-progress count.
- Load: `count` = min(`data_in`, `limit`), so an out-of-range load clamps to `limit`. `tc` = 0. Direction and mode are ignored.
- `en` low with no load: `count` holds and `tc` = 0.
- Up count (`en`=1, `control`=1):
  - `count < limit`: `count`+1, `tc` = 0.
  - `count >= limit`, wrap: `count` = 0, `tc` = 1.
  - `count >= limit`, saturate: `count` = `limit`, `tc` = 1. This also pulls an above-limit count back to `limit`.
- Down count (`en`=1, `control`=0):
  - `count > limit`: `count` = `limit`, `tc` = 0. This recovers from `limit` being lowered mid-count.
  - `0 < count <= limit`: `count`−1, `tc` = 0.
  - `count == 0`, wrap: `count` = `limit`, `tc` = 1.
  - `count == 0`, saturate: `count` = 0, `tc` = 1.
- `limit` = 0: up and down both yield `count` = 0 with `tc` = 1 on every enabled cycle, in both modes.
- `limit` = 2^WIDTH−1: full-range counting. Arithmetic is WIDTH bits and never relies on natural overflow; all comparisons are unsigned.
- In saturate mode, `tc` stays at 1 on every enabled cycle while pinned at an end.
- `control`, `mode` and `limit` may change on any cycle. The change takes effect on that same edge.

## Timing
- Latency: inputs are sampled on a rising edge, and `count` and `tc` reflect them after that edge (1 cycle).
- `tc` is asserted in the same cycle as the wrapped or saturated `count` value appears. It lasts one cycle per terminal event.
- `at_max` and `at_min` have zero latency from `count` and `limit`, with no registers.
- Reset asserted mid-count takes effect at the next edge. The first enabled edge after `rst` deasserts counts from RESET_VAL.
- No multicycle paths. The next-state logic is a single compare/increment level.

## Structure
- Shared package `updown_pkg` holds:
  - `DIR_UP` = 1 and `DIR_DOWN` = 0
  - `MODE_WRAP` = 0 and `MODE_SAT` = 1
- One sub-module, `updown_next`: purely combinational. It takes `count`, `limit`, `control` and `mode`, and returns `next_count` and `next_tc`. The top level holds the register, priority mux and flags.

## Test plan
All scenarios use WIDTH=4 and RESET_VAL=0.
1. Reset and load: `rst` for 1 cycle → `count`=0, `tc`=0, `at_min`=1. Then `load`=1, `data_in`=5, `limit`=15 → `count`=5 next cycle.
2. Up wrap: `limit`=9, `mode`=0, up from 7 → 8, 9, 0 (`tc`=1 only on the cycle showing 0), then 1.
3. Down saturate: `limit`=12, `mode`=1, down from 2 → 1, 0, 0, 0 with `tc`=1 on each cycle held at 0. Then switch to up → 1, `tc`=0.
4. Clamp and limit change: load 14 with `limit`=10 → `count`=10, `at_max`=1. Set `limit`=6 and count down → 6, 5.
5. Priority: `rst`=1 together with `load`=1, `data_in`=9 → `count`=0. Then `load`=1 with `en`=1, up, `data_in`=3 → `count`=3 (load wins).
6. Full range: `limit`=15, wrap, down from 0 → 15 with `tc`=1. `en`=0 for 3 cycles → `count` holds at 15 and `tc`=0.
